// File: rtl/uart_axil_fifo_bridge_if.sv
// AXI4-Lite (32-bit) bus between the UART FIFO bridge (master) and an AXI UART Lite (slave).
interface uart_axil_fifo_bridge_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/uart_axil_fifo_bridge.sv
// AXI4-Lite master bridging decoupled core TX/RX byte FIFOs to an AXI UART Lite.
// Optional macro UART_ERR_STICKY_EN adds sticky parity/frame/overrun flags (err_flags/err_clr).
module uart_axil_fifo_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RXQ_AW    = 4,
  parameter int          TXQ_AW    = 4
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [7:0]           tx_data,
  input  logic                 tx_push,
  output logic                 tx_ready,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_pop,
  output logic [TXQ_AW:0]      tx_count,
  output logic [RXQ_AW:0]      rx_count,
  output logic                 bus_err,
`ifdef UART_ERR_STICKY_EN
  output logic [2:0]           err_flags,
  input  logic                 err_clr,
`endif
  uart_axil_fifo_bridge_if.master m_axi
);

  typedef enum logic [2:0] {IDLE, ST_AR, ST_R, RX_AR, RX_R, TX_AW, TX_B} state_t;

  localparam logic [TXQ_AW:0] TX_ONE  = 1;
  localparam logic [RXQ_AW:0] RX_ONE  = 1;
  localparam logic [TXQ_AW:0] TX_FULL = {1'b1, {TXQ_AW{1'b0}}};
  localparam logic [RXQ_AW:0] RX_FULL = {1'b1, {RXQ_AW{1'b0}}};

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            bus_err_q, bus_err_d;
  logic [TXQ_AW:0] tx_wr_q, tx_rd_q;
  logic [RXQ_AW:0] rx_wr_q, rx_rd_q;
  logic [7:0]      tx_mem [0:(1<<TXQ_AW)-1];
  logic [7:0]      rx_mem [0:(1<<RXQ_AW)-1];

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
  logic rx_ok, tx_ok, aw_fire, w_fire;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic [7:0] tx_head;

  // Pointers carry an extra wrap bit: full when only the MSB differs.
  assign tx_full   = (tx_wr_q ^ tx_rd_q) == TX_FULL;
  assign tx_empty  = tx_wr_q == tx_rd_q;
  assign rx_full   = (rx_wr_q ^ rx_rd_q) == RX_FULL;
  assign rx_empty  = rx_wr_q == rx_rd_q;
  assign tx_push_ok = tx_push && !tx_full;
  assign rx_pop_ok  = rx_pop && !rx_empty;
  assign tx_head    = tx_mem[tx_rd_q[TXQ_AW-1:0]];

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_q[RXQ_AW-1:0]];
  assign tx_count = tx_wr_q - tx_rd_q;
  assign rx_count = rx_wr_q - rx_rd_q;
  assign bus_err  = bus_err_q;

  assign rx_ok = m_axi.rdata[0] && !rx_full;
  assign tx_ok = !m_axi.rdata[3] && !tx_empty;

  always_ff @(posedge CLK) begin
    if (tx_push_ok) tx_mem[tx_wr_q[TXQ_AW-1:0]] <= tx_data;
    if (rx_push_ok) rx_mem[rx_wr_q[RXQ_AW-1:0]] <= m_axi.rdata[7:0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bus_err_q <= bus_err_d;
      if (tx_push_ok) tx_wr_q <= tx_wr_q + TX_ONE;
      if (tx_pop_ok)  tx_rd_q <= tx_rd_q + TX_ONE;
      if (rx_push_ok) rx_wr_q <= rx_wr_q + RX_ONE;
      if (rx_pop_ok)  rx_rd_q <= rx_rd_q + RX_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bus_err_d  = 1'b0;
    tx_pop_ok  = 1'b0;
    rx_push_ok = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    aw_fire    = 1'b0;
    w_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty || !rx_full) state_d = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (m_axi.arready) state_d = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (m_axi.rvalid) begin
          if (m_axi.rresp != 2'b00) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end else if (rx_ok && tx_ok) begin
            state_d = rr_q ? TX_AW : RX_AR;
          end else if (rx_ok) begin
            state_d = RX_AR;
          end else if (tx_ok) begin
            state_d = TX_AW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RX_AR: begin
        arvalid = 1'b1;
        if (m_axi.arready) state_d = RX_R;
      end
      RX_R: begin
        rready = 1'b1;
        if (m_axi.rvalid) begin
          if (m_axi.rresp == 2'b00) begin
            rx_push_ok = 1'b1;
            rr_d       = 1'b1;
          end else begin
            bus_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      TX_AW: begin
        // Address and data channels complete independently, in either order.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_fire   = awvalid && m_axi.awready;
        w_fire    = wvalid && m_axi.wready;
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = TX_B;
        end
      end
      TX_B: begin
        bready = 1'b1;
        if (m_axi.bvalid) begin
          if (m_axi.bresp == 2'b00) begin
            tx_pop_ok = 1'b1;
            rr_d      = 1'b0;
          end else begin
            bus_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axi.araddr  = (state_q == RX_AR) ? BASE_ADDR : BASE_ADDR + 32'd8;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;
  assign m_axi.awaddr  = BASE_ADDR + 32'd4;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = {24'h000000, tx_head};
  assign m_axi.wstrb   = 4'b1111;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;

`ifdef UART_ERR_STICKY_EN
  logic [2:0] err_flags_q, err_flags_d;

  // A status capture in the same cycle as err_clr survives the clear.
  always_comb begin
    err_flags_d = err_clr ? 3'b000 : err_flags_q;
    if (state_q == ST_R && m_axi.rvalid && m_axi.rresp == 2'b00)
      err_flags_d = err_flags_d | m_axi.rdata[7:5];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) err_flags_q <= 3'b000;
    else       err_flags_q <= err_flags_d;
  end

  assign err_flags = err_flags_q;
`endif

  logic unused_rdata;
  assign unused_rdata = ^m_axi.rdata[31:8];

endmodule

// File: tb/tb_uart_axil_fifo_bridge.sv
// Self-checking bench: behavioural AXI UART Lite slave plus scoreboards for TX writes and RX bytes.
module tb_uart_axil_fifo_bridge;
  localparam logic [31:0] BASE = 32'h4060_0000;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_push = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop = 1'b0;
  logic [4:0] tx_count;
  logic [4:0] rx_count;
  logic       bus_err;

  uart_axil_fifo_bridge_if bus();

  uart_axil_fifo_bridge #(.BASE_ADDR(BASE), .RXQ_AW(4), .TXQ_AW(4)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .tx_data  (tx_data),
    .tx_push  (tx_push),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .bus_err  (bus_err),
    .m_axi    (bus)
  );

  always #5 CLK = ~CLK;

  int         vec = 0;
  int         miss = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  int         status_polls = 0;
  int         rx_reads = 0;
  int         writes = 0;
  int         busy_polls = 0;
  int         bresp_err_left = 0;
  int         wr_at_poll = 0;
  logic [7:0] status_base = 8'h04;
  logic [7:0] rx_next = 8'h10;
  bit         aw_stall = 1'b0;
  bit         prev_was_status = 1'b0;
  bit         rr_win = 1'b0;
  int         last_kind = 0;
  int         rr_viol = 0;

  // Behavioural UART Lite slave; samples 1 time unit after each rising edge.
  initial begin
    bit         ar_hs, r_hs, b_hs, aw_got, w_got;
    logic [31:0] ar_a;
    logic [7:0]  last_wbyte;
    logic [7:0]  st;
    ar_hs = 0; r_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
    ar_a = '0; last_wbyte = '0;
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    forever begin
      @(posedge CLK); #1;
      bus.awready = !aw_stall;
      bus.wready  = !aw_stall;
      if (!RSTN) begin
        ar_hs = 0; r_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
        bus.rvalid = 1'b0; bus.bvalid = 1'b0;
        continue;
      end
      if (r_hs) bus.rvalid = 1'b0;
      if (b_hs) bus.bvalid = 1'b0;
      if (ar_hs) begin
        bus.rvalid = 1'b1;
        bus.rresp  = 2'b00;
        if (ar_a == BASE + 32'd8) begin
          if (busy_polls > 0) begin
            st = 8'h08;
            busy_polls--;
          end else begin
            st = status_base;
          end
          bus.rdata = {24'h0, st};
          status_polls++;
          prev_was_status = 1'b1;
        end else if (ar_a == BASE) begin
          bus.rdata = {24'h0, rx_next};
          exp_rx.push_back(rx_next);
          $display("RX read  byte=%02h", rx_next);
          rx_next++;
          rx_reads++;
          prev_was_status = 1'b0;
          if (rr_win && last_kind == 1) rr_viol++;
          last_kind = 1;
        end else begin
          vec++; miss++;
          $display("FAIL araddr: got %08h, want %08h or %08h", ar_a, BASE, BASE + 32'd8);
        end
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0;
        bus.bvalid = 1'b1;
        if (bresp_err_left > 0) begin
          bus.bresp = 2'b10;
          bresp_err_left--;
          exp_wr.push_front(last_wbyte);
        end else begin
          bus.bresp = 2'b00;
        end
      end
      // Handshakes that complete at the coming edge.
      ar_hs = bus.arvalid && bus.arready;
      ar_a  = bus.araddr;
      r_hs  = bus.rvalid && bus.rready;
      b_hs  = bus.bvalid && bus.bready;
      if (bus.awvalid && bus.awready) begin
        aw_got = 1;
        vec++;
        if (bus.awaddr !== BASE + 32'd4) begin
          miss++;
          $display("FAIL awaddr: got %08h, want %08h", bus.awaddr, BASE + 32'd4);
        end
      end
      if (bus.wvalid && bus.wready) begin
        w_got = 1;
        last_wbyte = bus.wdata[7:0];
        writes++;
        wr_at_poll = status_polls;
        $display("TX write byte=%02h", bus.wdata[7:0]);
        vec++;
        if (!prev_was_status) begin
          miss++;
          $display("FAIL status_before_write: got no status read, want status read before %02h", bus.wdata[7:0]);
        end
        prev_was_status = 1'b0;
        if (rr_win && last_kind == 2) rr_viol++;
        last_kind = 2;
        vec++;
        if (exp_wr.size() == 0) begin
          miss++;
          $display("FAIL write_data: got unexpected %08h, want no write", bus.wdata);
        end else begin
          automatic logic [7:0] e = exp_wr.pop_front();
          if (bus.wdata !== {24'h0, e} || bus.wstrb !== 4'hF) begin
            miss++;
            $display("FAIL write_data: got %08h strb %h, want %08h strb f", bus.wdata, bus.wstrb, {24'h0, e});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    if (tx_ready) exp_wr.push_back(b);
    tick();
    tx_push = 1'b0;
  endtask

  task automatic wait_tx_drained(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || tx_count != 0) && n < 400) begin
      tick();
      n++;
    end
    vec++;
    if (tx_count !== 5'd0 || exp_wr.size() != 0) begin
      miss++;
      $display("FAIL %s: got tx_count=%0d pending=%0d, want 0/0", name, tx_count, exp_wr.size());
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (3) tick();
    vec++;
    if ({tx_ready, rx_valid, bus_err, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 8'b1000_0000) begin
      miss++;
      $display("FAIL reset_flags: got %b, want 10000000",
               {tx_ready, rx_valid, bus_err, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
    end
    vec++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0 || rx_data !== 8'h00) begin
      miss++;
      $display("FAIL reset_counts: got tx=%0d rx=%0d data=%02h, want 0 0 00", tx_count, rx_count, rx_data);
    end
    vec++;
    if (bus.wstrb !== 4'hF || bus.awprot !== 3'b000 || bus.arprot !== 3'b000) begin
      miss++;
      $display("FAIL constants: got strb=%h awprot=%0d arprot=%0d, want f 0 0", bus.wstrb, bus.awprot, bus.arprot);
    end
    RSTN = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_tx_basic();
    int w0 = writes;
    status_base = 8'h04;
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    wait_tx_drained("tx_basic_drain");
    vec++;
    if (writes - w0 != 3) begin
      miss++;
      $display("FAIL tx_basic_writes: got %0d, want 3", writes - w0);
    end
  endtask

  task automatic test_tx_backpressure();
    int p0, w0, n;
    status_base = 8'h04;
    busy_polls = 5;
    p0 = status_polls;
    w0 = writes;
    push_byte(8'h55);
    n = 0;
    while (writes == w0 && n < 300) begin tick(); n++; end
    vec++;
    if (wr_at_poll - p0 < 6) begin
      miss++;
      $display("FAIL tx_busy_polls: got write after %0d polls, want >= 6", wr_at_poll - p0);
    end
    repeat (30) tick();
    vec++;
    if (writes - w0 != 1) begin
      miss++;
      $display("FAIL tx_busy_writes: got %0d, want 1", writes - w0);
    end
    wait_tx_drained("tx_busy_drain");
  endtask

  task automatic test_rx_fill();
    int r0, n;
    logic [7:0] e;
    rx_next = 8'h10;
    status_base = 8'h01;
    n = 0;
    while (rx_count != 5'd16 && n < 400) begin tick(); n++; end
    repeat (20) tick();
    r0 = rx_reads;
    repeat (40) tick();
    vec++;
    if (rx_count !== 5'd16 || rx_reads != r0) begin
      miss++;
      $display("FAIL rx_full_hold: got count=%0d extra_reads=%0d, want 16 0", rx_count, rx_reads - r0);
    end
    e = exp_rx.pop_front();
    vec++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      miss++;
      $display("FAIL rx_head: got valid=%b data=%02h, want 1 %02h", rx_valid, rx_data, e);
    end
    $display("RX pop   byte=%02h", rx_data);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    n = 0;
    while ((rx_reads == r0 || rx_count != 5'd16) && n < 100) begin tick(); n++; end
    vec++;
    if (rx_reads != r0 + 1 || rx_count !== 5'd16) begin
      miss++;
      $display("FAIL rx_resume: got reads=%0d count=%0d, want 1 16", rx_reads - r0, rx_count);
    end
    status_base = 8'h04;
    repeat (10) tick();
  endtask

  task automatic test_latency();
    int n;
    vec++;
    if (bus.arvalid !== 1'b0) begin
      miss++;
      $display("FAIL idle_quiet: got arvalid=%b, want 0", bus.arvalid);
    end
    push_byte(8'h66);
    vec++;
    if (bus.arvalid !== 1'b0) begin
      miss++;
      $display("FAIL lat_n1: got arvalid=%b, want 0", bus.arvalid);
    end
    tick();
    vec++;
    if (bus.arvalid !== 1'b1) begin
      miss++;
      $display("FAIL lat_n2: got arvalid=%b, want 1", bus.arvalid);
    end
    n = 0;
    while (!(bus.rvalid && bus.rready) && n < 20) begin tick(); n++; end
    tick();
    vec++;
    if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin
      miss++;
      $display("FAIL lat_aw: got awvalid=%b wvalid=%b, want 1 1", bus.awvalid, bus.wvalid);
    end
    wait_tx_drained("lat_drain");
  endtask

  task automatic test_rx_drain();
    int n = 0;
    logic [7:0] e;
    while (rx_valid && n < 40) begin
      e = exp_rx.pop_front();
      vec++;
      if (rx_data !== e) begin
        miss++;
        $display("FAIL rx_data: got %02h, want %02h", rx_data, e);
      end
      $display("RX pop   byte=%02h", rx_data);
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
      n++;
    end
    vec++;
    if (rx_count !== 5'd0 || exp_rx.size() != 0 || n != 16) begin
      miss++;
      $display("FAIL rx_drain: got count=%0d left=%0d popped=%0d, want 0 0 16", rx_count, exp_rx.size(), n);
    end
  endtask

  task automatic test_bus_err();
    int w0, n, errs;
    bit bad_cnt;
    status_base = 8'h04;
    bresp_err_left = 1;
    w0 = writes;
    errs = 0;
    bad_cnt = 0;
    push_byte(8'h7E);
    n = 0;
    while (!(writes >= w0 + 2 && tx_count == 5'd0) && n < 300) begin
      if (bus_err) errs++;
      if (writes < w0 + 2 && tx_count !== 5'd1) bad_cnt = 1;
      tick();
      n++;
    end
    vec++;
    if (errs != 1) begin
      miss++;
      $display("FAIL bus_err_pulse: got %0d cycles, want 1", errs);
    end
    vec++;
    if (bad_cnt) begin
      miss++;
      $display("FAIL err_tx_count: got count != 1 before retry OKAY, want 1");
    end
    vec++;
    if (writes - w0 != 2 || tx_count !== 5'd0) begin
      miss++;
      $display("FAIL err_retry: got writes=%0d count=%0d, want 2 0", writes - w0, tx_count);
    end
  endtask

  task automatic test_round_robin();
    int w0, n;
    logic [7:0] e;
    status_base = 8'h01;
    w0 = writes;
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    rr_viol = 0;
    last_kind = 0;
    rr_win = 1'b1;
    n = 0;
    while (writes < w0 + 8 && n < 600) begin
      rx_pop = rx_valid;
      if (rx_valid) begin
        e = exp_rx.pop_front();
        vec++;
        if (rx_data !== e) begin
          miss++;
          $display("FAIL rr_rx_data: got %02h, want %02h", rx_data, e);
        end
      end
      tick();
      n++;
    end
    rx_pop = 1'b0;
    rr_win = 1'b0;
    vec++;
    if (rr_viol != 0 || writes != w0 + 8) begin
      miss++;
      $display("FAIL round_robin: got %0d repeats, %0d writes, want 0 repeats, 8 writes", rr_viol, writes - w0);
    end
    status_base = 8'h04;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    status_base = 8'h04;
    aw_stall = 1'b1;
    push_byte(8'h99);
    while (!bus.awvalid && n < 50) begin tick(); n++; end
    vec++;
    if (bus.awvalid !== 1'b1) begin
      miss++;
      $display("FAIL mid_aw_seen: got awvalid=%b, want 1", bus.awvalid);
    end
    #2 RSTN = 1'b0;
    #1;
    vec++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      miss++;
      $display("FAIL mid_reset_hs: got %b, want 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    vec++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0 || tx_ready !== 1'b1) begin
      miss++;
      $display("FAIL mid_reset_fifo: got tx=%0d rx=%0d ready=%b, want 0 0 1", tx_count, rx_count, tx_ready);
    end
    exp_wr.delete();
    exp_rx.delete();
    aw_stall = 1'b0;
    repeat (3) tick();
    RSTN = 1'b1;
    repeat (2) tick();
    push_byte(8'h5A);
    wait_tx_drained("post_reset_drain");
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_backpressure();
    test_rx_fill();
    test_latency();
    test_rx_drain();
    test_bus_err();
    test_round_robin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
